spi_dispatch_n: RTL and testbench

- Parametrised SPI-slave receive/dispatch block; successor to the fixed two-channel, 16-bit receiver.
- Captures DW-bit SPI frames in the clk_100 domain and decodes a TW-bit tag in the frame MSBs.
- Routes each valid frame to one of NCH channel registers with a one-cycle valid strobe, and queues a channel-selected reply word for the next frame.
- Adds short-frame, overrun and bad-tag detection with a saturating error counter.

---
 rtl/spi_dispatch_n.sv | 165 ++++++++++++++++
 tb/tb_spi_dispatch_n.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dispatch_n.sv
// SPI-slave (mode 0) frame receiver: synchronises SCK/SIMO/STE into clk_100, decodes a tag,
// routes frames to NCH channel registers and queues a tag-selected reply for the next frame.
module spi_dispatch_n #(
    parameter int DW          = 16,
    parameter int TW          = 2,
    parameter int NCH         = 2,
    parameter int REPLY_MODE  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100,
    input  logic              RST,
    input  logic              spi_sck,
    input  logic              spi_simo,
    output logic              spi_somi,
    input  logic              spi_ste,
    input  logic [NCH*DW-1:0] tx_data,
    output logic [NCH*DW-1:0] rx_data,
    output logic [NCH-1:0]    rx_valid,
    output logic [7:0]        err_cnt
);

    localparam int             CW   = $clog2(DW + 1);
    localparam logic [CW-1:0]  FULL = CW'(DW);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_simo_sync;
    logic [SYNC_STAGES-1:0] r_ste_sync;
    logic                   r_sck_prev;
    logic                   r_ste_prev;

    logic [DW-1:0]     r_rx_shift;
    logic [DW-1:0]     r_tx_shift;
    logic [DW-1:0]     r_reply;
    logic [CW-1:0]     r_count;
    logic              r_overrun;
    logic [NCH*DW-1:0] r_rx_data;
    logic [NCH-1:0]    r_rx_valid;
    logic [7:0]        r_err_cnt;

    logic          w_sck;
    logic          w_simo;
    logic          w_ste;
    logic          w_sck_rise;
    logic          w_sck_fall;
    logic          w_ste_rise;
    logic          w_ste_fall;
    logic [TW-1:0] w_tag;
    logic          w_tag_ok;
    logic          w_frame_ok;

    // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk_100 or posedge RST) begin
        if (RST) begin
            r_sck_sync  <= '0;
            r_simo_sync <= '0;
            r_ste_sync  <= '0;
            r_sck_prev  <= 1'b0;
            r_ste_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_simo_sync <= {r_simo_sync[SYNC_STAGES-2:0], spi_simo};
            r_ste_sync  <= {r_ste_sync[SYNC_STAGES-2:0], spi_ste};
            r_sck_prev  <= w_sck;
            r_ste_prev  <= w_ste;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_simo     = r_simo_sync[SYNC_STAGES-1];
    assign w_ste      = r_ste_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_ste_rise = w_ste & ~r_ste_prev;
    assign w_ste_fall = ~w_ste & r_ste_prev;

    assign w_tag      = r_rx_shift[DW-1 -: TW];
    assign w_tag_ok   = (w_tag != '0) && (int'(w_tag) <= NCH);
    assign w_frame_ok = (r_count == FULL) && !r_overrun && w_tag_ok;

    always_ff @(posedge clk_100 or posedge RST) begin
        if (RST) r_state <= ST_WAIT;
        else     r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT:  if (w_ste)      w_next_state = ST_IDLE;
            ST_IDLE:  if (w_ste_fall) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_ste_rise) w_next_state = ST_DONE;
            ST_DONE:                  w_next_state = ST_IDLE;
            default:                  w_next_state = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk_100 or posedge RST) begin
        if (RST) begin
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_reply    <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_rx_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ste_fall) begin
                        r_tx_shift <= r_reply;
                        r_rx_shift <= '0;
                        r_count    <= '0;
                        r_overrun  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // An SCK edge coinciding with STE rising belongs to no frame and is dropped.
                    if (!w_ste_rise) begin
                        if (w_sck_rise) begin
                            if (r_count < FULL) begin
                                r_rx_shift <= {r_rx_shift[DW-2:0], w_simo};
                                r_count    <= r_count + CW'(1);
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end
                        if (w_sck_fall) r_tx_shift <= {r_tx_shift[DW-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (!w_frame_ok) begin
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else begin
                        for (int c = 1; c <= NCH; c++) begin
                            if (w_tag == TW'(c)) begin
                                r_rx_data[(c-1)*DW +: DW] <= r_rx_shift;
                                r_rx_valid[c-1]           <= 1'b1;
                                r_reply <= tx_data[(((REPLY_MODE != 0) ? (NCH + 1 - c) : c) - 1)*DW +: DW];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_somi = (r_state == ST_SHIFT) ? r_tx_shift[DW-1] : 1'b0;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_spi_dispatch_n.sv
// Self-checking bench for spi_dispatch_n: a bit-banged mode-0 SPI master drives frames and a
// frame-level reference model predicts reply bits, channel words, strobe timing and error count.
module tb_spi_dispatch_n;

    localparam int DW          = 16;
    localparam int TW          = 2;
    localparam int NCH         = 2;
    localparam int REPLY_MODE  = 1;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 5;
    localparam int TRACE       = 6;
    localparam int LAT         = SYNC_STAGES + 2;

    logic              clk_100 = 1'b0;
    logic              RST;
    logic              spi_sck;
    logic              spi_simo;
    logic              spi_somi;
    logic              spi_ste;
    logic [NCH*DW-1:0] tx_data;
    logic [NCH*DW-1:0] rx_data;
    logic [NCH-1:0]    rx_valid;
    logic [7:0]        err_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reply;
    logic [DW-1:0] m_rx [1:NCH];
    int            m_err;

    logic [31:0]          obs_miso, exp_miso;
    logic [TRACE*NCH-1:0] obs_trace, exp_trace;

    spi_dispatch_n #(
        .DW(DW), .TW(TW), .NCH(NCH), .REPLY_MODE(REPLY_MODE), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_100 (clk_100),
        .RST     (RST),
        .spi_sck (spi_sck),
        .spi_simo(spi_simo),
        .spi_somi(spi_somi),
        .spi_ste (spi_ste),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .err_cnt (err_cnt)
    );

    always #5 clk_100 = ~clk_100;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] tx_word(input int c);
        return tx_data[(c-1)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rx_word(input int c);
        return rx_data[(c-1)*DW +: DW];
    endfunction

    task automatic model_reset();
        m_reply = '0;
        for (int c = 1; c <= NCH; c++) m_rx[c] = '0;
        m_err = 0;
    endtask

    // Frame-level rules: reply bits come from the queued reply, a good frame lands in its
    // channel and strobes LAT cycles after STE rises, anything else bumps the error count.
    task automatic model_frame(input logic [31:0] word, input int nbits);
        int tag;
        exp_miso  = '0;
        exp_trace = '0;
        for (int i = 0; i < nbits; i++)
            exp_miso = {exp_miso[30:0], (i < DW) ? m_reply[DW-1-i] : 1'b0};
        tag = int'(word[DW-1 -: TW]);
        if (nbits != DW || tag < 1 || tag > NCH) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end else begin
            m_rx[tag] = word[DW-1:0];
            exp_trace[(LAT-1)*NCH + tag - 1] = 1'b1;
            m_reply = tx_word((REPLY_MODE != 0) ? NCH + 1 - tag : tag);
        end
    endtask

    task automatic clock_bit(input logic b, output logic so);
        spi_simo = b;
        repeat (HALF) @(negedge clk_100);
        so      = spi_somi;
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk_100);
        spi_sck = 1'b0;
    endtask

    task automatic capture_trace();
        obs_trace = '0;
        for (int k = 0; k < TRACE; k++) begin
            @(negedge clk_100);
            obs_trace[k*NCH +: NCH] = rx_valid;
        end
    endtask

    task automatic do_frame(input logic [31:0] word, input int nbits,
                            input int chg_bit, input logic [NCH*DW-1:0] chg_tx);
        logic so;
        obs_miso = '0;
        spi_ste  = 1'b0;
        repeat (HALF) @(negedge clk_100);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) tx_data = chg_tx;
            clock_bit(word[nbits-1-i], so);
            obs_miso = {obs_miso[30:0], so};
        end
        repeat (HALF) @(negedge clk_100);
        spi_ste = 1'b1;
        capture_trace();
        model_frame(word, nbits);
        repeat (2) @(negedge clk_100);
    endtask

    task automatic test_reset();
        RST = 1'b1; spi_sck = 1'b0; spi_simo = 1'b0; spi_ste = 1'b1; tx_data = '0;
        model_reset();
        repeat (3) @(negedge clk_100);
        checks++;
        if (rx_data !== '0 || rx_valid !== '0 || err_cnt !== 8'd0 || spi_somi !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rx_data=%h rx_valid=%b err_cnt=%0d somi=%b, required all zero",
                     rx_data, rx_valid, err_cnt, spi_somi);
        end
        RST = 1'b0;
        repeat (8) @(negedge clk_100);
        checks++;
        if (rx_valid !== '0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset: rx_valid=%b err_cnt=%0d, required 0/0", rx_valid, err_cnt);
        end
    endtask

    task automatic test_dispatch();
        logic [15:0] words [3] = '{16'h4ABC, 16'h8123, 16'h0000};
        tx_data = {16'h2222, 16'h1111};
        foreach (words[i]) begin
            do_frame({16'h0, words[i]}, DW, -1, '0);
            checks++;
            if (obs_miso !== exp_miso) begin
                errors++;
                $display("FAIL dispatch_miso[%0d]: got %h want %h", i, obs_miso, exp_miso);
            end
            checks++;
            if (obs_trace !== exp_trace) begin
                errors++;
                $display("FAIL dispatch_strobe[%0d]: got %b want %b", i, obs_trace, exp_trace);
            end
            checks++;
            if (rx_word(1) !== m_rx[1] || rx_word(2) !== m_rx[2]) begin
                errors++;
                $display("FAIL dispatch_rx[%0d]: got %h/%h want %h/%h",
                         i, rx_word(1), rx_word(2), m_rx[1], m_rx[2]);
            end
            checks++;
            if (int'(err_cnt) !== m_err) begin
                errors++;
                $display("FAIL dispatch_err[%0d]: got %0d want %0d", i, err_cnt, m_err);
            end
        end
    endtask

    task automatic test_bad_length();
        int lens [2] = '{12, 17};
        int err_before = m_err;
        foreach (lens[i]) begin
            do_frame(32'h1_4ABC, lens[i], -1, '0);
            checks++;
            if (obs_trace !== '0 || obs_miso !== exp_miso) begin
                errors++;
                $display("FAIL bad_length[%0d]: strobe=%b miso=%h want strobe=0 miso=%h",
                         lens[i], obs_trace, obs_miso, exp_miso);
            end
        end
        checks++;
        if (int'(err_cnt) !== err_before + 2) begin
            errors++;
            $display("FAIL bad_length_err: got %0d want %0d", err_cnt, err_before + 2);
        end
    endtask

    task automatic test_reset_midframe();
        logic so;
        spi_ste = 1'b0;
        repeat (HALF) @(negedge clk_100);
        for (int i = 0; i < 8; i++) clock_bit(i[0], so);
        RST = 1'b1;
        repeat (2) @(negedge clk_100);
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) clock_bit(i[1], so);
        repeat (HALF) @(negedge clk_100);
        spi_ste = 1'b1;
        capture_trace();
        checks++;
        if (obs_trace !== '0 || err_cnt !== 8'd0 || rx_data !== '0) begin
            errors++;
            $display("FAIL reset_abort: strobe=%b err_cnt=%0d rx_data=%h, required all zero",
                     obs_trace, err_cnt, rx_data);
        end
        do_frame(32'h4001, DW, -1, '0);
        checks++;
        if (obs_trace !== exp_trace || rx_word(1) !== m_rx[1] || obs_miso !== exp_miso) begin
            errors++;
            $display("FAIL reset_recover: strobe=%b rx1=%h miso=%h want %b/%h/%h",
                     obs_trace, rx_word(1), obs_miso, exp_trace, m_rx[1], exp_miso);
        end
    endtask

    task automatic test_tx_change();
        do_frame(32'h5555, DW, 8, {16'h3333, 16'h1111});
        checks++;
        if (obs_miso !== exp_miso) begin
            errors++;
            $display("FAIL tx_inflight: got %h want %h", obs_miso, exp_miso);
        end
        do_frame(32'h4242, DW, -1, '0);
        checks++;
        if (obs_miso !== exp_miso || exp_miso !== 32'h3333) begin
            errors++;
            $display("FAIL tx_next: got %h want %h", obs_miso, exp_miso);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 18)) : DW;
            logic [31:0] word = $urandom;
            logic [NCH*DW-1:0] new_tx = {$urandom, $urandom};
            do_frame(word, nbits, int'($urandom_range(0, DW - 1)), new_tx);
            checks++;
            if (obs_miso !== exp_miso || obs_trace !== exp_trace) begin
                errors++;
                $display("FAIL random[%0d]: miso=%h strobe=%b want %h/%b",
                         n, obs_miso, obs_trace, exp_miso, exp_trace);
            end
            checks++;
            if (rx_word(1) !== m_rx[1] || rx_word(2) !== m_rx[2] || int'(err_cnt) !== m_err) begin
                errors++;
                $display("FAIL random_state[%0d]: rx=%h/%h err=%0d want %h/%h/%0d",
                         n, rx_word(1), rx_word(2), err_cnt, m_rx[1], m_rx[2], m_err);
            end
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            do_frame(32'hC000, DW, -1, '0);
            checks++;
            if (int'(err_cnt) !== m_err || obs_trace !== '0) begin
                errors++;
                $display("FAIL saturate[%0d]: err=%0d strobe=%b want %0d/0", n, err_cnt, obs_trace, m_err);
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate_final: got %0d want 255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_bad_length();
        test_reset_midframe();
        test_tx_change();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
